// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the key event generator.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_e;

    localparam int COUNT_W = 8;

    function automatic int timer_width(input int long_cycles,
                                       input int repeat_cycles);
        int m;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_gen_hold_timer.sv
// Hold-duration up-counter with clear, increment enable and terminal compare.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == terminal);

endmodule

// File: rtl/key_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses
// and keeps a wrapping press counter.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               level,
    input  logic               en,
    output logic               press,
    output logic               key_release,
    output logic               long_press,
    output logic               key_repeat,
    output logic               held,
    output logic [COUNT_W-1:0] press_count
);

    localparam int TW = timer_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [TW-1:0] LONG_TERM   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_TERM = TW'(REPEAT_CYCLES - 1);

    key_state_e         state_q, state_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               rel_q, rel_d;
    logic               long_q, long_d;
    logic               rpt_q, rpt_d;
    logic               held_q, held_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic          t_clr;
    logic          t_inc;
    logic          t_done;
    logic [TW-1:0] t_term;

    assign t_term = (state_q == LONG) ? REPEAT_TERM : LONG_TERM;

    hold_timer #(
        .W(TW)
    ) u_hold_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (t_clr),
        .inc     (t_inc),
        .terminal(t_term),
        .done    (t_done)
    );

    always_comb begin
        state_d = state_q;
        level_d = level;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        t_clr   = 1'b1;
        t_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level && !level_q) begin
                    state_d = PRESSED;
                    press_d = en;
                end
            end
            PRESSED: begin
                if (!level) begin
                    state_d = IDLE;
                    rel_d   = en;
                end else if (t_done) begin
                    state_d = LONG;
                    long_d  = en;
                end else begin
                    t_clr = 1'b0;
                    t_inc = 1'b1;
                end
            end
            LONG: begin
                if (!level) begin
                    state_d = IDLE;
                    rel_d   = en;
                end else if (t_done) begin
                    rpt_d = en;
                end else begin
                    t_clr = 1'b0;
                    t_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG);
        cnt_d  = cnt_q + {{(COUNT_W-1){1'b0}}, press_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press       = press_q;
    assign key_release = rel_q;
    assign long_press  = long_q;
    assign key_repeat  = rpt_q;
    assign held        = held_q;
    assign press_count = cnt_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench: a hold-age model predicts every output per cycle.
module tb_key_event_gen;

    localparam int LC = 8;
    localparam int RC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       level;
    logic       en;
    logic       press;
    logic       key_release;
    logic       long_press;
    logic       key_repeat;
    logic       held;
    logic [7:0] press_count;

    key_event_gen #(
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .level      (level),
        .en         (en),
        .press      (press),
        .key_release(key_release),
        .long_press (long_press),
        .key_repeat (key_repeat),
        .held       (held),
        .press_count(press_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       p;
        logic       r;
        logic       l;
        logic       rp;
        logic       h;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   press_seen;

    bit   m_active;
    int   m_age;
    bit   m_lq;
    byte unsigned m_cnt;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want,
                     $time);
        end
    endtask

    task automatic step(input bit rst, input bit e, input bit lv);
        exp_t x;
        @(negedge clock);
        reset = rst;
        en    = e;
        level = lv;
        x = '0;
        if (rst) begin
            m_active = 0;
            m_age    = 0;
            m_lq     = 0;
            m_cnt    = 0;
        end else begin
            if (!m_active) begin
                if (lv && !m_lq) begin
                    m_active = 1;
                    m_age    = 0;
                    x.p      = e;
                    if (e) m_cnt = m_cnt + 8'd1;
                end
            end else if (!lv) begin
                m_active = 0;
                x.r      = e;
            end else begin
                m_age++;
                x.l  = e && (m_age == LC);
                x.rp = e && (m_age > LC) && ((m_age - LC) % RC == 0);
            end
            m_lq = lv;
        end
        x.h   = m_active;
        x.cnt = m_cnt;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        x = exp_q.pop_front();
        check("press", {7'd0, press}, {7'd0, x.p});
        check("release", {7'd0, key_release}, {7'd0, x.r});
        check("long_press", {7'd0, long_press}, {7'd0, x.l});
        check("repeat", {7'd0, key_repeat}, {7'd0, x.rp});
        check("held", {7'd0, held}, {7'd0, x.h});
        check("press_count", press_count, x.cnt);
        if (press === 1'b1) press_seen++;
    endtask

    task automatic hold(input bit e, input bit lv, input int n);
        for (int i = 0; i < n; i++) step(0, e, lv);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        level = 1'b0;
        m_active = 0;
        m_age = 0;
        m_lq = 0;
        m_cnt = 0;
        press_seen = 0;

        step(1, 1, 0);
        step(1, 1, 0);
        check("reset_count", press_count, 8'd0);

        // short press of 3 cycles
        hold(1, 1, 3);
        hold(1, 0, 3);
        check("short_count", press_count, 8'd1);

        // long hold of 20 cycles: long at +8, repeats at +12, +16
        hold(1, 1, 20);
        hold(1, 0, 3);

        // release exactly at the long_press edge
        hold(1, 1, 8);
        hold(1, 0, 3);

        // en low at press, raised at E0+5
        step(1, 1, 0);
        hold(0, 1, 5);
        hold(1, 1, 15);
        hold(1, 0, 3);
        check("en_count", press_count, 8'd0);

        // 256 short presses wrap the counter
        step(1, 1, 0);
        press_seen = 0;
        for (int k = 0; k < 256; k++) begin
            hold(1, 1, 2);
            hold(1, 0, 2);
        end
        check("wrap_presses", press_seen[7:0], 8'd0);
        check("wrap_presses_hi", 8'(press_seen >> 8), 8'd1);
        check("wrap_count", press_count, 8'd0);

        // reset in the middle of a long hold, level kept high
        hold(1, 1, 10);
        step(1, 1, 1);
        step(1, 1, 1);
        hold(1, 1, 3);
        check("rst_hold_count", press_count, 8'd1);
        hold(1, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
